tens_complement_generator: RTL and testbench
============================================

Name: tens_complement_generator

Overview:
- Registered BCD ten's-complement unit: computes (10^NDIGITS − N) mod 10^NDIGITS of a packed BCD operand N.
- Flags non-BCD operands instead of producing garbage.
- Sits in the decimal-arithmetic datapath, feeding BCD subtractors (A − B = A + tenscomp(B)).
- Default configuration is a single 4-bit digit.

Parameters:
- NDIGITS, 1, number of packed BCD digits in the operand (≥1); data width = 4*NDIGITS.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand strobe; input_number is sampled on a clk edge when high
- input_number  input  4*NDIGITS  packed BCD operand; digit 0 in bits [3:0]
- out_valid  output  1  high for one cycle when tens_complement/error are updated
- tens_complement  output  4*NDIGITS  packed BCD result
- error  output  1  operand contained a digit > 9

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, tens_complement=0, error=0. Release is synchronous to clk.
- Latency: exactly 1 cycle. A clk edge with in_valid=1 registers the result; out_valid=1 for that cycle.
- Edge with in_valid=0: out_valid=0; tens_complement and error hold their last values.
- No backpressure. in_valid may be high every cycle (throughput 1/cycle).
- Arithmetic, per digit i:
  - nines_i = 9 − d_i.
  - Add 1 at digit 0 and ripple a decimal carry upward.
  - When nines_i + carry_in = 10, the digit becomes 0 and carry_out = 1; otherwise the digit is nines_i + carry_in and carry_out = 0.
  - Carry out of the top digit is discarded.
- Single-digit table: 0→0, 1→9, 2→8, 3→7, 4→6, 5→5, 6→4, 7→3, 8→2, 9→1.
- All-zero operand → all-zero result (modular wrap), error=0.
- Invalid digit (any nibble 10..15): error=1 and tens_complement forced to all zeros. out_valid still pulses normally.
- Reset asserted mid-operation: the pending result is discarded, and out_valid is 0 on the first edge after release.
- Combinational path input→output does not exist; all outputs are flops.

Optional Feature:
- Macro TENS_COMP_NINES_OUT_EN.
- Defined:
  - Adds output port nines_complement (4*NDIGITS), registered alongside tens_complement.
  - Each digit is 9 − d_i.
  - Forced to 0 when error=1.
  - Reset value 0.
- Undefined: the port and its flops are absent; all other behaviour is identical.

Decomposition:
- Package tens_comp_pkg:
  - BCD_DIGIT_W=4, BCD_MAX=4'd9.
  - typedef bcd_digit_t (logic [3:0]).
  - function is_bcd(bcd_digit_t).
- Sub-module tens_comp_digit_cell (combinational, one per digit, generate loop).
  - Inputs: digit, carry_in.
  - Outputs: nines digit, tens digit, carry_out, digit_invalid.
- Top level: the ripple chain, error OR-reduction, zero-forcing mux and output registers.

Test Plan:
- Reset: hold rst_n=0 with in_valid=1, input_number=4'b0110 → out_valid=0, tens_complement=0, error=0. First edge after release with in_valid=1 → 4'b0100 next cycle.
- Valid sweep (NDIGITS=1): 0,1,5,6,9 → 0,9,5,4,1 one cycle later. out_valid asserted each cycle, no bubbles.
- Invalid operands: 4'b1010 → tens_complement=0, error=1. 4'b1101 → 0, error=1. Following 4'b0110 → 4'b0100, error=0.
- Hold: in_valid=1 with 4'b0011 (→7), then in_valid=0 with input changed to 4'b1000 → out_valid=0, tens_complement stays 7.
- Multi-digit (NDIGITS=2):
  - 8'h37 → 8'h63.
  - 8'h40 → 8'h60.
  - 8'h00 → 8'h00.
  - 8'h99 → 8'h01.
  - 8'h3A → 8'h00, error=1.
- Mid-operation reset: pulse rst_n low asynchronously between edges after in_valid=1 → outputs clear immediately, no stale out_valid. With TENS_COMP_NINES_OUT_EN defined, 4'b0110 → nines_complement=4'b0011.

Source files
------------

// File: rtl/tens_comp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tens_comp_pkg
// Description : Shared BCD definitions for the ten's-complement generator.
//               - BCD_DIGIT_W : width of one packed BCD digit
//               - BCD_MAX     : largest legal BCD digit value
//               - bcd_digit_t : one packed BCD digit
//               - is_bcd()    : returns 1 when a nibble is a legal BCD digit
// Revision    : 1.0 - initial release
// ============================================================================
package tens_comp_pkg;

    localparam int         BCD_DIGIT_W = 4;
    localparam logic [3:0] BCD_MAX     = 4'd9;

    typedef logic [BCD_DIGIT_W-1:0] bcd_digit_t;

    function automatic logic is_bcd(input bcd_digit_t d);
        return (d <= BCD_MAX);
    endfunction

endpackage : tens_comp_pkg
`default_nettype wire

// File: rtl/tens_comp_digit_cell.sv
`default_nettype none
// ============================================================================
// Module      : tens_comp_digit_cell
// Description : Combinational single-digit slice of the BCD ten's-complement
//               ripple chain. Forms the nine's complement of the digit, adds
//               the incoming decimal carry and produces the outgoing carry.
// Ports       : i_digit         - BCD digit of the operand
//               i_carry_in      - decimal carry from the digit below
//               o_nines         - 9 - digit
//               o_tens          - (9 - digit + carry_in) mod 10
//               o_carry_out     - decimal carry to the digit above
//               o_digit_invalid - digit is outside 0..9
// Revision    : 1.0 - initial release
// ============================================================================
module tens_comp_digit_cell
    import tens_comp_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] i_digit,
    input  logic                   i_carry_in,
    output logic [BCD_DIGIT_W-1:0] o_nines,
    output logic [BCD_DIGIT_W-1:0] o_tens,
    output logic                   o_carry_out,
    output logic                   o_digit_invalid
);

    localparam logic [BCD_DIGIT_W:0] c_DEC_BASE = (BCD_DIGIT_W+1)'(10);

    logic [BCD_DIGIT_W:0] w_sum;

    always_comb begin
        o_nines         = BCD_MAX - i_digit;
        o_digit_invalid = ~is_bcd(i_digit);
        w_sum           = {1'b0, o_nines} + {{BCD_DIGIT_W{1'b0}}, i_carry_in};
        o_tens          = w_sum[BCD_DIGIT_W-1:0];
        o_carry_out     = 1'b0;
        // A legal nine's digit is at most 9, so only the exact value 10 can
        // overflow the decimal digit. Illegal digits produce junk here, but
        // the top level forces the whole result to zero in that case.
        if (w_sum == c_DEC_BASE) begin
            o_tens      = '0;
            o_carry_out = 1'b1;
        end
    end

endmodule : tens_comp_digit_cell
`default_nettype wire

// File: rtl/tens_complement_generator.sv
`default_nettype none
// ============================================================================
// Module      : tens_complement_generator
// Description : Registered BCD ten's-complement unit. Computes
//               (10^NDIGITS - N) mod 10^NDIGITS of a packed BCD operand with
//               one cycle of latency and a throughput of one per cycle.
//               Operands with any nibble > 9 raise error and yield zero.
// Parameters  : NDIGITS - number of packed BCD digits (>= 1)
// Ports       : clk              - rising-edge clock
//               rst_n            - asynchronous active-low reset
//               in_valid         - operand strobe
//               input_number     - packed BCD operand, digit 0 in [3:0]
//               out_valid        - one-cycle pulse when results update
//               tens_complement  - packed BCD ten's complement
//               error            - operand contained a non-BCD digit
//               nines_complement - packed BCD nine's complement
//                                  (present only with TENS_COMP_NINES_OUT_EN)
// Options     : define TENS_COMP_NINES_OUT_EN to add nines_complement
// Revision    : 1.0 - initial release
// ============================================================================
module tens_complement_generator
    import tens_comp_pkg::*;
#(
    parameter int NDIGITS = 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    input  logic [BCD_DIGIT_W*NDIGITS-1:0] input_number,
    output logic                           out_valid,
    output logic [BCD_DIGIT_W*NDIGITS-1:0] tens_complement,
    output logic                           error
`ifdef TENS_COMP_NINES_OUT_EN
    ,
    output logic [BCD_DIGIT_W*NDIGITS-1:0] nines_complement
`endif
);

    localparam int DATA_W = BCD_DIGIT_W * NDIGITS;

    logic [NDIGITS:0]   w_carry;
    logic [NDIGITS-1:0] w_digit_invalid;
    logic [DATA_W-1:0]  w_tens;
    logic [DATA_W-1:0]  w_nines;
    logic               w_error;
    logic [DATA_W-1:0]  w_tens_masked;
    logic               w_carry_unused;

    // The "+1" of the ten's complement enters as the carry into digit 0.
    assign w_carry[0] = 1'b1;

    for (genvar gi = 0; gi < NDIGITS; gi++) begin : g_digit
        tens_comp_digit_cell u_cell (
            .i_digit         (input_number[gi*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .i_carry_in      (w_carry[gi]),
            .o_nines         (w_nines[gi*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .o_tens          (w_tens[gi*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .o_carry_out     (w_carry[gi+1]),
            .o_digit_invalid (w_digit_invalid[gi])
        );
    end

    // Carry out of the top digit is the modular wrap and is dropped.
    assign w_carry_unused = w_carry[NDIGITS];

    assign w_error       = |w_digit_invalid;
    assign w_tens_masked = w_error ? '0 : w_tens;

    logic              r_out_valid;
    logic [DATA_W-1:0] r_tens;
    logic              r_error;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_tens      <= '0;
            r_error     <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_tens  <= w_tens_masked;
                r_error <= w_error;
            end
        end
    end

    assign out_valid       = r_out_valid;
    assign tens_complement = r_tens;
    assign error           = r_error;

`ifdef TENS_COMP_NINES_OUT_EN
    logic [DATA_W-1:0] r_nines;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_nines <= '0;
        end else if (in_valid) begin
            r_nines <= w_error ? '0 : w_nines;
        end
    end

    assign nines_complement = r_nines;
`else
    logic w_nines_unused;
    assign w_nines_unused = ^w_nines;
`endif

endmodule : tens_complement_generator
`default_nettype wire

// File: tb/tb_tens_complement_generator.sv
`default_nettype none
// ============================================================================
// Module      : tb_tens_complement_generator
// Description : Self-checking bench for tens_complement_generator. Drives a
//               single-digit instance and a two-digit instance side by side
//               and compares both against an arithmetic reference model.
// Options     : honours TENS_COMP_NINES_OUT_EN
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tens_complement_generator;

    localparam int NA = 1;
    localparam int NB = 2;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       va    = 1'b0;
    logic [3:0] ina   = '0;
    logic       vb    = 1'b0;
    logic [7:0] inb   = '0;

    logic       a_ov, a_err, b_ov, b_err;
    logic [3:0] a_tc;
    logic [7:0] b_tc;
`ifdef TENS_COMP_NINES_OUT_EN
    logic [3:0] a_nc;
    logic [7:0] b_nc;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    tens_complement_generator #(.NDIGITS(NA)) u_dut_a (
        .clk              (clk),
        .rst_n            (rst_n),
        .in_valid         (va),
        .input_number     (ina),
        .out_valid        (a_ov),
        .tens_complement  (a_tc),
        .error            (a_err)
`ifdef TENS_COMP_NINES_OUT_EN
        ,
        .nines_complement (a_nc)
`endif
    );

    tens_complement_generator #(.NDIGITS(NB)) u_dut_b (
        .clk              (clk),
        .rst_n            (rst_n),
        .in_valid         (vb),
        .input_number     (inb),
        .out_valid        (b_ov),
        .tens_complement  (b_tc),
        .error            (b_err)
`ifdef TENS_COMP_NINES_OUT_EN
        ,
        .nines_complement (b_nc)
`endif
    );

    // ---------------- reference model (plain decimal arithmetic) -------------
    function automatic int digit_of(input logic [31:0] n, input int i);
        return int'((n >> (4*i)) & 32'hF);
    endfunction

    function automatic logic ref_err(input logic [31:0] n, input int nd);
        for (int i = 0; i < nd; i++)
            if (digit_of(n, i) > 9) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] ref_tc(input logic [31:0] n, input int nd);
        int val = 0;
        int p   = 1;
        int r;
        logic [31:0] res = '0;
        if (ref_err(n, nd)) return '0;
        for (int i = 0; i < nd; i++) begin
            val += digit_of(n, i) * p;
            p   *= 10;
        end
        r = (p - val) % p;
        for (int i = 0; i < nd; i++) begin
            res |= 32'(r % 10) << (4*i);
            r   /= 10;
        end
        return res;
    endfunction

    function automatic logic [31:0] ref_nines(input logic [31:0] n, input int nd);
        logic [31:0] res = '0;
        if (ref_err(n, nd)) return '0;
        for (int i = 0; i < nd; i++)
            res |= 32'(9 - digit_of(n, i)) << (4*i);
        return res;
    endfunction

    logic        ma_v, mb_v, ma_e, mb_e;
    logic [31:0] ma_tc, mb_tc, ma_nc, mb_nc;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ma_v <= 1'b0; ma_e <= 1'b0; ma_tc <= '0; ma_nc <= '0;
            mb_v <= 1'b0; mb_e <= 1'b0; mb_tc <= '0; mb_nc <= '0;
        end else begin
            ma_v <= va;
            mb_v <= vb;
            if (va) begin
                ma_tc <= ref_tc(32'(ina), NA);
                ma_e  <= ref_err(32'(ina), NA);
                ma_nc <= ref_nines(32'(ina), NA);
            end
            if (vb) begin
                mb_tc <= ref_tc(32'(inb), NB);
                mb_e  <= ref_err(32'(inb), NB);
                mb_nc <= ref_nines(32'(inb), NB);
            end
        end
    end

    // ---------------- checking ----------------------------------------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        check("a_valid", 32'(a_ov),  32'(ma_v));
        check("a_tc",    32'(a_tc),  ma_tc);
        check("a_err",   32'(a_err), 32'(ma_e));
        check("b_valid", 32'(b_ov),  32'(mb_v));
        check("b_tc",    32'(b_tc),  mb_tc);
        check("b_err",   32'(b_err), 32'(mb_e));
`ifdef TENS_COMP_NINES_OUT_EN
        check("a_nines", 32'(a_nc),  ma_nc);
        check("b_nines", 32'(b_nc),  mb_nc);
`endif
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------------------------------------
    logic [3:0] sw_in  [5] = '{4'h0, 4'h1, 4'h5, 4'h6, 4'h9};
    logic [3:0] sw_exp [5] = '{4'h0, 4'h9, 4'h5, 4'h4, 4'h1};
    logic [7:0] mb_in  [5] = '{8'h40, 8'h00, 8'h99, 8'h3A, 8'h37};
    logic [7:0] mb_exp [5] = '{8'h60, 8'h00, 8'h01, 8'h00, 8'h63};
    logic       mb_er  [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    initial begin
        // Pin the reference model against hand-computed values.
        check("pin_tc_1",  ref_tc(32'h1, 1),  32'h9);
        check("pin_tc_37", ref_tc(32'h37, 2), 32'h63);
        check("pin_tc_99", ref_tc(32'h99, 2), 32'h01);
        check("pin_err_3A", 32'(ref_err(32'h3A, 2)), 32'h1);

        // Reset held with a valid operand present.
        rst_n = 1'b0;
        va = 1'b1; ina = 4'h6;
        vb = 1'b1; inb = 8'h37;
        repeat (3) step();
        check("rst_valid", 32'(a_ov),  32'h0);
        check("rst_tc",    32'(a_tc),  32'h0);
        check("rst_err",   32'(a_err), 32'h0);

        fork
            forever begin
                @(negedge clk);
                compare_all();
            end
        join_none

        rst_n = 1'b1;
        step();
        check("post_rst_tc",    32'(a_tc), 32'h4);
        check("post_rst_valid", 32'(a_ov), 32'h1);
        check("b_37",           32'(b_tc), 32'h63);

        // Back-to-back sweep on both instances.
        for (int i = 0; i < 5; i++) begin
            ina = sw_in[i];
            inb = mb_in[i];
            step();
            check("sweep_a_tc",    32'(a_tc),  32'(sw_exp[i]));
            check("sweep_a_valid", 32'(a_ov),  32'h1);
            check("sweep_b_tc",    32'(b_tc),  32'(mb_exp[i]));
            check("sweep_b_err",   32'(b_err), 32'(mb_er[i]));
        end

        // Invalid operands followed by recovery.
        ina = 4'hA; step();
        check("inv_A_tc",  32'(a_tc),  32'h0);
        check("inv_A_err", 32'(a_err), 32'h1);
        ina = 4'hD; step();
        check("inv_D_tc",  32'(a_tc),  32'h0);
        check("inv_D_err", 32'(a_err), 32'h1);
        ina = 4'h6; step();
        check("recov_tc",  32'(a_tc),  32'h4);
        check("recov_err", 32'(a_err), 32'h0);

        // Hold when in_valid drops.
        ina = 4'h3; step();
        check("hold_pre_tc", 32'(a_tc), 32'h7);
        va = 1'b0; ina = 4'h8; step();
        check("hold_valid", 32'(a_ov), 32'h0);
        check("hold_tc",    32'(a_tc), 32'h7);

`ifdef TENS_COMP_NINES_OUT_EN
        va = 1'b1; ina = 4'h6; step();
        check("nines_6", 32'(a_nc), 32'h3);
`endif

        // Asynchronous reset between edges.
        va = 1'b1; ina = 4'h6; step();
        check("mid_pre_valid", 32'(a_ov), 32'h1);
        #1 rst_n = 1'b0;
        #1;
        check("mid_valid", 32'(a_ov), 32'h0);
        check("mid_tc",    32'(a_tc), 32'h0);
        check("mid_b_tc",  32'(b_tc), 32'h0);
        #1 rst_n = 1'b1;
        va = 1'b0; vb = 1'b0;
        step();
        check("mid_after_valid", 32'(a_ov), 32'h0);

        // Randomized traffic checked every cycle by the compare loop.
        repeat (400) begin
            va  = ($urandom_range(0, 3) != 0);
            ina = 4'($urandom);
            vb  = ($urandom_range(0, 3) != 0);
            inb = 8'($urandom);
            step();
        end
        va = 1'b0; vb = 1'b0;
        repeat (2) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_tens_complement_generator
`default_nettype wire
